// File: rtl/memory_mc.sv
// Single-port word memory controller with fixed access latency, byte-enabled writes,
// and a misalignment flag reported alongside the one-cycle completion pulse.
module memory_mc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    data_valid,
  output logic                    err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  r_state, w_nxt_state;
  logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
  logic                    w_accept, w_complete;

  logic                    r_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_din;
  logic [BYTES-1:0]        r_be;

  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_busy, r_valid, r_err;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_misalign;

  assign w_idx      = DEPTH_LOG2'(r_addr >> OFFS);
  assign w_misalign = (r_addr & ADDR_WIDTH'((1 << OFFS) - 1)) != '0;

  assign data_out   = r_dout;
  assign busy       = r_busy;
  assign data_valid = r_valid;
  assign err        = r_err;

  // Next-state: accept in IDLE, count down in BUSY, complete when the counter hits zero.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_accept    = 1'b1;
          w_nxt_state = BUSY;
          w_nxt_cnt   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_nxt_state = IDLE;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_be    <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_busy  <= (w_nxt_state == BUSY);
      r_valid <= w_complete;
      r_err   <= w_complete & w_misalign;
      if (w_accept) begin
        r_wr   <= wr;
        r_addr <= addr;
        r_din  <= data_in;
        r_be   <= byte_en;
      end
      // Misaligned accesses of either kind report zero data.
      if (w_complete && (w_misalign || !r_wr)) begin
        r_dout <= w_misalign ? '0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset; an access aborted by reset never reaches completion.
  always_ff @(posedge clk) begin
    if (w_complete && r_wr && !w_misalign) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_din[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_mc.sv
// Directed bench for memory_mc: stimulus pushes expected completions to a queue,
// an independent monitor pops and compares on every data_valid pulse.
module tb_memory_mc;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 4;

  typedef struct {
    bit          chk_data;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [1:0]    byte_en;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          data_valid;
  logic          err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  memory_mc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(4), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .byte_en(byte_en), .data_out(data_out),
    .busy(busy), .data_valid(data_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_valid=1 expected no pending access at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_err", 32'(err), 32'(e.err));
        if (e.chk_data) check("resp_data", 32'(data_out), 32'(e.data));
      end
    end
  end

  // Present a request for one edge; the following edge must have accepted it.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    @(negedge clk);
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    byte_en = be;
    @(negedge clk);
    enable  = 1'b0;
    wr      = ~w;
    addr    = 16'hFFFF;
    data_in = 16'h0000;
    byte_en = 2'b00;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (data_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
  endtask

  task automatic push(input bit cd, input logic [15:0] d, input logic e);
    exp_t x;
    x.chk_data = cd;
    x.data     = d;
    x.err      = e;
    sb_q.push_back(x);
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] exp_d, input logic exp_e);
    push(!w || exp_e, exp_d, exp_e);
    issue(w, a, d, be);
    wait_done();
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;
    byte_en = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_dout",  32'(data_out),   32'd0);
    rst_n = 1'b1;

    // Full write then read back
    access(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0);

    // Low-byte-only write merges with existing word
    access(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000, 1'b0);
    access(1'b1, 16'h0020, 16'hABCD, 2'b01, 16'h0000, 1'b0);
    access(1'b0, 16'h0020, 16'h0000, 2'b00, 16'h12CD, 1'b0);
    // byte_en=0 write leaves the word alone
    access(1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
    access(1'b0, 16'h0020, 16'h0000, 2'b00, 16'h12CD, 1'b0);

    // Back-to-back: enable held high gives one accept every LAT+1 cycles
    repeat (3) push(1'b1, 16'hBEEF, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wr     = 1'b0;
    addr   = 16'h0010;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("stream_busy",  32'(busy),       32'((k % 5) != 4));
      check("stream_valid", 32'(data_valid), 32'((k % 5) == 4));
    end
    enable = 1'b0;

    // Misaligned read, then aligned read of the same word
    access(1'b0, 16'h0011, 16'h0000, 2'b00, 16'h0000, 1'b1);
    check("misalign_dout_zero", 32'(data_out), 32'd0);
    access(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0);

    // Reset mid-write aborts the access
    issue(1'b1, 16'h0010, 16'h1111, 2'b11);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
    access(1'b0, 16'h0020, 16'h0000, 2'b00, 16'h12CD, 1'b0);

    // 16-word array: byte 0x0040 aliases byte 0x0000
    access(1'b1, 16'h0040, 16'h5A5A, 2'b11, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 2'b00, 16'h5A5A, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
